// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//
// Purpose:
//   Walks a 4-input gate block through all sixteen {W,X,Y,Z} input codes.
//   The walk starts at START_CODE and wraps modulo 16. The scanner records
//   the gate's V response for each code into a 16-bit table. It also counts
//   how many entries disagree with a golden table supplied by the user.
//   Each code is held for SETTLE+1 cycles. V is sampled on the last of
//   those cycles.
//
// Parameters:
//   SETTLE     : extra hold cycles per vector before V is sampled (0..15)
//   START_CODE : first {W,X,Y,Z} code of every scan
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous active-high reset
//   start      in   1  scan request, only looked at while idle
//   expected   in  16  golden truth table, bit index = {W,X,Y,Z}
//   v_in       in   1  V output of the gate block under test
//   w,x,y,z    out  1  registered drive to gate inputs W,X,Y,Z
//   busy       out  1  high while a scan is in progress
//   done       out  1  one-cycle pulse after the 16th sample
//   tbl        out 16  captured truth table, bit index = {W,X,Y,Z}
//                      (named tbl because "table" is a reserved word)
//   err_count  out  5  number of captured bits differing from expected
//   mismatch   out  1  err_count != 0
module truth_table_scanner #(
  parameter int         SETTLE     = 1,
  parameter logic [3:0] START_CODE = 4'b1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        v_in,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic        busy,
  output logic        done,
  output logic [15:0] tbl,
  output logic [4:0]  err_count,
  output logic        mismatch
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Last value of the settle counter before moving to SAMPLE.
  // When SETTLE is 0, DRIVE is never entered and this value is unused.
  localparam int         SETTLE_LAST_I = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [3:0] SETTLE_LAST   = SETTLE_LAST_I[3:0];
  // After a start or a code step, DRIVE is skipped entirely when there is
  // no settle time.
  localparam state_t     STEP_STATE    = (SETTLE == 0) ? S_SAMPLE : S_DRIVE;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_code;
  logic [3:0]  r_settle_cnt;
  logic [3:0]  r_sample_cnt;   // samples already taken in this scan
  logic [15:0] r_table;
  logic [4:0]  r_err_count;

  logic        w_accept;
  logic        w_sample;
  logic        w_last_sample;

  assign w_accept      = (r_state == S_IDLE) && start;
  assign w_sample      = (r_state == S_SAMPLE);
  assign w_last_sample = (r_sample_cnt == 4'd15);

  // Next-state and decoded outputs
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = STEP_STATE;
      end
      S_DRIVE: begin
        busy = 1'b1;
        if (r_settle_cnt == SETTLE_LAST) w_next_state = S_SAMPLE;
      end
      S_SAMPLE: begin
        busy         = 1'b1;
        w_next_state = w_last_sample ? S_DONE : STEP_STATE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, vector drive, capture and error accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_code       <= 4'd0;
      r_settle_cnt <= 4'd0;
      r_sample_cnt <= 4'd0;
      r_table      <= 16'h0000;
      r_err_count  <= 5'd0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_code       <= START_CODE;
        r_settle_cnt <= 4'd0;
        r_sample_cnt <= 4'd0;
        r_table      <= 16'h0000;
        r_err_count  <= 5'd0;
      end else if (w_sample) begin
        // Golden bit is read at the sample edge, so late edits to
        // expected only affect codes not yet visited.
        r_table[r_code] <= v_in;
        if (v_in != expected[r_code]) r_err_count <= r_err_count + 5'd1;
        r_sample_cnt <= r_sample_cnt + 4'd1;
        r_settle_cnt <= 4'd0;
        // After the final sample the code is left in place so w..z keep
        // showing the last vector through DONE and IDLE.
        if (!w_last_sample) r_code <= r_code + 4'd1;
      end else if (r_state == S_DRIVE) begin
        r_settle_cnt <= r_settle_cnt + 4'd1;
      end
    end
  end

  assign {w, x, y, z} = r_code;
  assign tbl          = r_table;
  assign err_count    = r_err_count;
  assign mismatch     = (r_err_count != 5'd0);

endmodule

// File: tb/tb_truth_table_scanner.sv
// Testbench for truth_table_scanner.
// Two instances are used: index 0 has SETTLE=0 and index 1 has SETTLE=1.
// Each gate block is modelled as a lookup into a bench-owned 16-bit table g,
// so a scan must reproduce g. The error count must equal popcount(g ^ expected).
module tb_truth_table_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  err;
    int          busy_cycles;
  } exp_t;

  exp_t        sb_q [2][$];

  logic [1:0]  rst_a;
  logic [1:0]  start_a;
  logic [15:0] exp_a [2];
  logic [15:0] g_a   [2];

  logic [1:0]  busy_a;
  logic [1:0]  done_a;
  logic [1:0]  mism_a;
  logic [3:0]  code_a [2];
  logic [15:0] tbl_a  [2];
  logic [4:0]  err_a  [2];

  int n_checks = 0;
  int n_errs   = 0;

  function automatic void chk(input string nm, input int d,
                              input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s dut%0d: got %0h required %0h", nm, d, act, req);
    end
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_dut
    logic [3:0]  code;
    logic        busy, done, mismatch;
    logic [15:0] tbl;
    logic [4:0]  err_count;

    truth_table_scanner #(.SETTLE(d), .START_CODE(4'b1000)) u_dut (
      .clk       (clk),
      .rst       (rst_a[d]),
      .start     (start_a[d]),
      .expected  (exp_a[d]),
      .v_in      (g_a[d][code]),
      .w         (code[3]),
      .x         (code[2]),
      .y         (code[1]),
      .z         (code[0]),
      .busy      (busy),
      .done      (done),
      .tbl       (tbl),
      .err_count (err_count),
      .mismatch  (mismatch)
    );

    assign busy_a[d] = busy;
    assign done_a[d] = done;
    assign mism_a[d] = mismatch;
    assign code_a[d] = code;
    assign tbl_a[d]  = tbl;
    assign err_a[d]  = err_count;

    // Monitor: tracks each scan and checks it against the scoreboard on done
    initial begin : mon
      exp_t        e;
      int          busy_cnt;
      logic [15:0] seen;
      logic [3:0]  first, last;
      logic        prev_done;
      busy_cnt  = 0;
      seen      = 16'h0;
      first     = 4'h0;
      last      = 4'h0;
      prev_done = 1'b0;
      forever begin
        @(negedge clk);
        if (rst_a[d] !== 1'b0) begin
          busy_cnt  = 0;
          seen      = 16'h0;
          prev_done = 1'b0;
        end else begin
          if (busy === 1'b1) begin
            if (busy_cnt == 0) first = code;
            busy_cnt++;
            seen[code] = 1'b1;
            last = code;
          end
          if (done === 1'b1) begin
            chk("done_one_cycle", d, 32'(prev_done), 32'd0);
            chk("busy_low_in_done", d, 32'(busy), 32'd0);
            if (sb_q[d].size() == 0) begin
              n_checks++;
              n_errs++;
              $display("FAIL unexpected_done dut%0d: got done=1 required no done", d);
            end else begin
              e = sb_q[d].pop_front();
              chk("table", d, 32'(tbl), 32'(e.tbl));
              chk("err_count", d, 32'(err_count), 32'(e.err));
              chk("mismatch", d, 32'(mismatch), 32'(e.err != 5'd0));
              chk("busy_cycles", d, 32'(busy_cnt), 32'(e.busy_cycles));
              chk("first_code", d, 32'(first), 32'h8);
              chk("last_code", d, 32'(last), 32'h7);
              chk("codes_covered", d, 32'(seen), 32'hFFFF);
            end
            busy_cnt = 0;
            seen     = 16'h0;
          end
          prev_done = done;
        end
      end
    end
  end

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while (done_a[d] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_a[d] !== 1'b1) begin
      n_checks++;
      n_errs++;
      $display("FAIL done_timeout dut%0d: got no done in %0d cycles required done", d, n);
    end
  endtask

  task automatic push_exp(input int d, input logic [15:0] g, input logic [15:0] e);
    exp_t item;
    item.tbl         = g;
    item.err         = 5'($countones(g ^ e));
    item.busy_cycles = 16 * (d + 1);
    sb_q[d].push_back(item);
  endtask

  task automatic scan(input int d, input logic [15:0] g, input logic [15:0] e);
    g_a[d]   = g;
    exp_a[d] = e;
    push_exp(d, g, e);
    start_a[d] = 1'b1;
    @(negedge clk);
    start_a[d] = 1'b0;
    wait_done(d);
    repeat (3) @(negedge clk);
    chk("table_held", d, 32'(tbl_a[d]), 32'(g));
    chk("err_held", d, 32'(err_a[d]), 32'($countones(g ^ e)));
    chk("code_held", d, 32'(code_a[d]), 32'h7);
    chk("idle_not_busy", d, 32'(busy_a[d]), 32'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int done_at;
    logic [15:0] g, e;
    rst_a   = 2'b11;
    start_a = 2'b11;
    for (int d = 0; d < 2; d++) begin
      exp_a[d] = 16'h0;
      g_a[d]   = 16'h0;
    end

    // Reset held two cycles with start asserted
    repeat (2) @(negedge clk);
    rst_a   = 2'b00;
    start_a = 2'b00;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_code", d, 32'(code_a[d]), 32'h0);
      chk("rst_busy", d, 32'(busy_a[d]), 32'd0);
      chk("rst_done", d, 32'(done_a[d]), 32'd0);
      chk("rst_table", d, 32'(tbl_a[d]), 32'h0);
      chk("rst_err", d, 32'(err_a[d]), 32'h0);
      chk("rst_mismatch", d, 32'(mism_a[d]), 32'h0);
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) chk("no_scan_after_rst", d, 32'(busy_a[d]), 32'd0);

    // Gate V = X|Y|Z gives 16'hFEFE
    scan(1, 16'hFEFE, 16'hFEFE);
    scan(1, 16'hFEFE, 16'hFFFF);
    // Gate tied low against an all-ones golden table: 16 errors
    scan(0, 16'h0000, 16'hFFFF);
    scan(0, 16'hFEFE, 16'hFEFE);

    for (int i = 0; i < 8; i++) begin
      g = 16'($urandom);
      e = (i % 3 == 0) ? g : 16'($urandom);
      scan(i % 2, g, e);
    end

    // Start held high for 40 cycles: two back-to-back scans
    g = 16'($urandom);
    e = 16'($urandom);
    g_a[1]   = g;
    exp_a[1] = e;
    push_exp(1, g, e);
    push_exp(1, g, e);
    start_a[1] = 1'b1;
    done_at = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_a[1] === 1'b1 && done_at < 0) done_at = c;
      if (done_at >= 0 && c == done_at + 1) chk("restart_idle_cycle", 1, 32'(busy_a[1]), 32'd0);
      if (done_at >= 0 && c == done_at + 2) chk("restart_busy", 1, 32'(busy_a[1]), 32'd1);
    end
    chk("first_done_at", 1, 32'(done_at), 32'd32);
    start_a[1] = 1'b0;
    wait_done(1);
    repeat (3) @(negedge clk);

    // Reset landing on the 5th sample edge aborts the scan
    g_a[1]   = 16'hFFFF;
    exp_a[1] = 16'h0000;
    start_a[1] = 1'b1;
    @(negedge clk);
    start_a[1] = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_abort_err", 1, 32'(err_a[1]), 32'd4);
    rst_a[1] = 1'b1;
    @(negedge clk);
    rst_a[1] = 1'b0;
    chk("abort_busy", 1, 32'(busy_a[1]), 32'd0);
    chk("abort_table", 1, 32'(tbl_a[1]), 32'h0);
    chk("abort_err", 1, 32'(err_a[1]), 32'h0);
    chk("abort_mismatch", 1, 32'(mism_a[1]), 32'h0);
    chk("abort_code", 1, 32'(code_a[1]), 32'h0);
    chk("abort_done", 1, 32'(done_a[1]), 32'h0);
    repeat (40) @(negedge clk);
    chk("abort_not_resumed", 1, 32'(busy_a[1]), 32'd0);

    // Normal operation after the abort
    scan(1, 16'h1234, 16'h1235);

    for (int d = 0; d < 2; d++) chk("scoreboard_drained", d, 32'(sb_q[d].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL have parameter SETTLE, default 1, giving the extra cycles each input vector is held before V is sampled (legal range 0..15).
REQ-002 SHALL have parameter START_CODE, default 4'b1000, giving the first {W,X,Y,Z} code of every scan.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a scan request sampled only in IDLE.
REQ-006 SHALL have port expected, input, 16, the golden truth table, bit index = {W,X,Y,Z}.
REQ-007 SHALL have port v_in, input, 1, the V output of the downstream 4-input gate block.
REQ-008 SHALL have ports w, x, y, z, each output, 1, registered drive to the gate block inputs W, X, Y, Z.
REQ-009 SHALL have port busy, output, 1, high while a scan is in progress.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse on scan completion.
REQ-011 SHALL have port table, output, 16, the captured truth table, bit index = {W,X,Y,Z}.
REQ-012 SHALL have port err_count, output, 5, the count of bits where table differs from expected (0..16).
REQ-013 SHALL have port mismatch, output, 1, high when err_count is nonzero.

Function
REQ-014 SHALL implement the FSM states IDLE, DRIVE, SAMPLE and DONE.
REQ-015 SHALL, in IDLE with start=1, load code=START_CODE, drive {w,x,y,z}=START_CODE, clear table, clear err_count and clear sample count, then go to DRIVE.
REQ-016 SHALL hold each vector on w..z for exactly SETTLE+1 cycles: DRIVE counts SETTLE cycles, then SAMPLE; with SETTLE=0, DRIVE lasts zero cycles.
REQ-017 SHALL, at the SAMPLE edge, write table[code] <= v_in and increment err_count by 1 if v_in != expected[code].
REQ-018 SHALL, after a SAMPLE that is not the 16th sample, set code <= code+1 modulo 16 (4'b1111 wraps to 4'b0000), update w..z on the same edge, and return to DRIVE.
REQ-019 SHALL, after the 16th SAMPLE, go to DONE; DONE asserts done=1 for one cycle, then returns to IDLE.
REQ-020 SHALL cover every code exactly once per scan: the total scan is 16*(SETTLE+1) cycles from the start-accept edge to the last sample, and done is high in the following cycle.
REQ-021 SHALL drive busy=1 in DRIVE and SAMPLE, and busy=0 in IDLE and DONE.
REQ-022 SHALL ignore start in DRIVE, SAMPLE and DONE; if start is held high continuously, a new scan begins on the first IDLE cycle after DONE.
REQ-023 SHALL hold table, err_count and mismatch stable from DONE until the next accepted start.
REQ-024 SHALL derive mismatch combinationally as err_count != 0.
REQ-025 SHALL hold w..z at the last driven code while in DONE and IDLE; they change only on start-accept or a code step.
REQ-026 SHALL capture expected per bit at the SAMPLE edge, so changing expected mid-scan affects only bits not yet sampled.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, force state=IDLE, w=x=y=z=0, busy=0, done=0, table=16'h0000, err_count=0 and all internal counters to 0.
REQ-028 SHALL give rst priority over start and over any in-progress scan; a scan aborted by reset is not resumed.

Verification
REQ-029 SHALL be verified by this scenario: rst=1 for 2 cycles, start=1 during reset -> after the release, all outputs are 0, busy=0, and no scan has started.
REQ-030 SHALL be verified by this scenario: SETTLE=1, v_in modelled as X|Y|Z, expected=16'hFEFE, one-cycle start -> busy=1 for 32 cycles, the first code is 4'b1000 and the last is 4'b0111, done pulses once, table=16'hFEFE, err_count=0, mismatch=0.
REQ-031 SHALL be verified by this scenario: the same as REQ-030 but with expected=16'hFFFF -> table=16'hFEFE, err_count=2, mismatch=1.
REQ-032 SHALL be verified by this scenario: SETTLE=0, v_in tied to 0, expected=16'hFFFF -> busy=1 for 16 cycles, table=16'h0000, err_count=5'd16.
REQ-033 SHALL be verified by this scenario: start held high for 40 cycles with SETTLE=1 -> the first scan is unaffected, done is seen once, and a second scan begins on the cycle after DONE.
REQ-034 SHALL be verified by this scenario: rst pulsed for 1 cycle at the 5th sample -> the next cycle shows state IDLE, table=0, err_count=0, busy=0, and no done pulse.
